gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Parametrised synchronous Gray-code counter; successor to the combinational 4-bit binary-to-Gray converter.
- Keeps an internal binary count and outputs both the binary value and its registered Gray encoding.
- Adds up/down counting, parallel load, enable, wrap-or-saturate mode and a terminal-event flag.
- Used for clock-domain-safe pointers (FIFO addresses) and position encoders elsewhere in the design.

Parameters:
- WIDTH, 4, counter and code width in bits (>= 2).
- SATURATE, 0: 0 = wrap at the ends; 1 = hold at the ends.
- RESET_VAL, 0, binary value loaded on reset (WIDTH bits).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous, active-low reset.
- en, input, 1, count enable; one step per clock while high.
- up_dn, input, 1, direction: 1 = increment, 0 = decrement.
- load, input, 1, synchronous parallel load.
- load_bin, input, WIDTH, binary value to load.
- bin, output, WIDTH, current binary count (registered).
- gray, output, WIDTH, Gray code of bin (registered): gray = bin ^ (bin >> 1).
- tc, output, 1, terminal-event pulse (registered, one cycle).

Behaviour:
- Reset: rst_n sampled low at a rising edge sets bin = RESET_VAL, gray = RESET_VAL ^ (RESET_VAL >> 1) and tc = 0. Reset is synchronous only; there is no asynchronous path.
- Priority per edge: reset, then load, then en, then hold.
- Load: bin <= load_bin and gray <= load_bin ^ (load_bin >> 1) on the same edge. tc <= 0. en and up_dn are ignored that cycle.
- Count, en=1 and load=0:
  - up_dn=1: bin <= bin + 1.
  - up_dn=0: bin <= bin - 1.
  - Arithmetic is modulo 2^WIDTH.
- Gray output:
  - gray is computed from next-state bin and registered in the same flop stage as bin.
  - Latency from a load or step edge to both bin and gray is 1 clock.
  - The two outputs are never skewed.
- Terminal handling, SATURATE=0:
  - Up step from 2^WIDTH-1 wraps to 0.
  - Down step from 0 wraps to 2^WIDTH-1.
  - tc = 1 for exactly the cycle following the wrapping edge.
- Terminal handling, SATURATE=1:
  - Up step at 2^WIDTH-1, or down step at 0, leaves bin and gray unchanged.
  - tc = 1 for the cycle following each such blocked step, so tc stays high while en is held at the limit.
- tc = 0 after any non-terminal step, load, hold or reset.
- Hold (en=0, load=0): bin, gray unchanged; tc <= 0.
- Gray property: every enabled non-blocked step changes exactly one bit of gray, including the wrap step. A load may change any number of bits.
- Direction change: up_dn is sampled every edge; reversing direction mid-count is legal and takes effect immediately.
- Reset mid-operation: overrides load and en on that edge. The first step after reset release starts from RESET_VAL.
- No combinational path from any input to any output.

Test Plan:
- Reset and up-count, WIDTH=4, RESET_VAL=0: hold rst_n=0 for 2 clocks, then en=1, up_dn=1 for 16 clocks.
  - Expect bin 0→15→0 and gray sequence 0000,0001,0011,0010,0110,…,1000,0000.
  - tc=1 only in the cycle after 15→0.
  - Every step has Hamming distance 1.
- Down-count wrap: load_bin=1 with load=1, then en=1, up_dn=0 for 3 clocks.
  - Expect bin 1,0,15,14 and gray 0001,0000,1000,1001.
  - tc=1 once, after the 0→15 step.
- Saturate, SATURATE=1: load 14, en=1, up_dn=1 for 4 clocks.
  - Expect bin 15,15,15,15 and gray 1000 held.
  - tc=0 after the 14→15 step, then 1 for each blocked step.
- Load priority: en=1, up_dn=1, load=1, load_bin=9 on the same edge.
  - Expect bin=9, gray=1101, tc=0; counting resumes 10 next cycle.
- Synchronous reset mid-count, RESET_VAL=5: counting at bin=11, assert rst_n=0 for one edge together with load=1.
  - Expect bin=5, gray=0111, tc=0; deasserting rst_n between edges must not change outputs.
- Enable/direction toggling: from bin=7, apply en=0 for 2 clocks, then up_dn toggled each clock with en=1.
  - Expect bin 7,7,8,7,8 and gray 0100,0100,1100,0100,1100.

Source files
------------

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
// Module   : gray_counter
// Purpose  : Up/down binary counter with registered Gray-coded twin output,
//            parallel load, enable, wrap-or-saturate ends and terminal pulse.
// Revision : 1.0 - initial release
// ============================================================================
module gray_counter #(
   parameter int                    WIDTH     = 4,
   parameter int                    SATURATE  = 0,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray,
   output logic             tc
);

   localparam logic [WIDTH-1:0] c_one        = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_max        = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] c_reset_gray = RESET_VAL ^ (RESET_VAL >> 1);

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_tc;

   logic [WIDTH-1:0] w_bin_nxt;
   logic [WIDTH-1:0] w_gray_nxt;
   logic             w_tc_nxt;
   logic             w_at_end;

   always_comb begin
      w_bin_nxt = r_bin;
      w_tc_nxt  = 1'b0;
      w_at_end  = up_dn ? (r_bin == c_max) : (r_bin == '0);
      if (load) begin
         w_bin_nxt = load_bin;
      end else if (en) begin
         w_tc_nxt = w_at_end;
         // In saturate mode a step at the limit is swallowed but still flagged.
         if (!(w_at_end && (SATURATE != 0))) begin
            w_bin_nxt = up_dn ? (r_bin + c_one) : (r_bin - c_one);
         end
      end
      w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bin  <= RESET_VAL;
         r_gray <= c_reset_gray;
         r_tc   <= 1'b0;
      end else begin
         r_bin  <= w_bin_nxt;
         r_gray <= w_gray_nxt;
         r_tc   <= w_tc_nxt;
      end
   end

   assign bin  = r_bin;
   assign gray = r_gray;
   assign tc   = r_tc;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_counter
// Purpose  : Scoreboard bench for three gray_counter configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_counter;

   typedef struct {
      int         id;
      logic [3:0] b;
      logic [3:0] g;
      logic       tc;
      logic       hd;
      string      nm;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n    [3];
   logic       en       [3];
   logic       up_dn    [3];
   logic       load     [3];
   logic [3:0] load_bin [3];
   logic [3:0] bin_o    [3];
   logic [3:0] gray_o   [3];
   logic       tc_o     [3];

   exp_t       sb[$];
   logic [3:0] prev_gray [3];
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   // 0: wrap, reset 0   1: saturate, reset 0   2: wrap, reset 5
   gray_counter #(.WIDTH(4), .SATURATE(0), .RESET_VAL(4'd0)) u_wrap (
      .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .up_dn(up_dn[0]), .load(load[0]),
      .load_bin(load_bin[0]), .bin(bin_o[0]), .gray(gray_o[0]), .tc(tc_o[0]));
   gray_counter #(.WIDTH(4), .SATURATE(1), .RESET_VAL(4'd0)) u_sat (
      .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .up_dn(up_dn[1]), .load(load[1]),
      .load_bin(load_bin[1]), .bin(bin_o[1]), .gray(gray_o[1]), .tc(tc_o[1]));
   gray_counter #(.WIDTH(4), .SATURATE(0), .RESET_VAL(4'd5)) u_rv5 (
      .clk(clk), .rst_n(rst_n[2]), .en(en[2]), .up_dn(up_dn[2]), .load(load[2]),
      .load_bin(load_bin[2]), .bin(bin_o[2]), .gray(gray_o[2]), .tc(tc_o[2]));

   // Monitor: outputs are stable mid-cycle; drain whatever the stimulus queued.
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (bin_o[e.id] !== e.b || gray_o[e.id] !== e.g || tc_o[e.id] !== e.tc) begin
               n_fail++;
               $display("FAIL %s dut%0d: got bin=%0d gray=%b tc=%b, want bin=%0d gray=%b tc=%b",
                        e.nm, e.id, bin_o[e.id], gray_o[e.id], tc_o[e.id], e.b, e.g, e.tc);
            end
            if (e.hd) begin
               n_tests++;
               if ($countones(gray_o[e.id] ^ prev_gray[e.id]) != 1) begin
                  n_fail++;
                  $display("FAIL %s_hamming dut%0d: got gray %b after %b, want distance 1",
                           e.nm, e.id, gray_o[e.id], prev_gray[e.id]);
               end
            end
            prev_gray[e.id] = gray_o[e.id];
         end
      end
   end

   task automatic step(input int id, input logic r, input logic l, input logic e,
                       input logic u, input logic [3:0] lb, input logic [3:0] xb,
                       input logic [3:0] xg, input logic xtc, input logic hd,
                       input string nm);
      exp_t x;
      rst_n[id] = r; load[id] = l; en[id] = e; up_dn[id] = u; load_bin[id] = lb;
      @(posedge clk);
      #1;
      x.id = id; x.b = xb; x.g = xg; x.tc = xtc; x.hd = hd; x.nm = nm;
      sb.push_back(x);
   endtask

   logic [3:0] up_gray [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100,
                                4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                4'b1011, 4'b1001, 4'b1000, 4'b0000};

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0; en[i] = 1'b0; up_dn[i] = 1'b1; load[i] = 1'b0;
         load_bin[i] = 4'd0; prev_gray[i] = 4'd0;
      end

      // Reset then full up-count with wrap
      step(0, 0, 0, 0, 1, 4'd0, 4'd0, 4'b0000, 0, 0, "reset0");
      step(0, 0, 0, 0, 1, 4'd0, 4'd0, 4'b0000, 0, 0, "reset1");
      for (int k = 1; k <= 16; k++)
         step(0, 1, 0, 1, 1, 4'd0, 4'(k), up_gray[k-1], (k == 16), 1, "upcount");

      // Down-count wrap
      step(0, 1, 1, 0, 0, 4'd1, 4'd1,  4'b0001, 0, 0, "dn_load");
      step(0, 1, 0, 1, 0, 4'd0, 4'd0,  4'b0000, 0, 1, "dn_1to0");
      step(0, 1, 0, 1, 0, 4'd0, 4'd15, 4'b1000, 1, 1, "dn_wrap");
      step(0, 1, 0, 1, 0, 4'd0, 4'd14, 4'b1001, 0, 1, "dn_15to14");

      // Load wins over enable
      step(0, 1, 1, 1, 1, 4'd9, 4'd9,  4'b1101, 0, 0, "load_prio");
      step(0, 1, 0, 1, 1, 4'd0, 4'd10, 4'b1111, 0, 1, "load_resume");

      // Enable / direction toggling from 7
      step(0, 1, 1, 0, 1, 4'd7, 4'd7, 4'b0100, 0, 0, "tog_load7");
      step(0, 1, 0, 0, 1, 4'd0, 4'd7, 4'b0100, 0, 0, "tog_hold_a");
      step(0, 1, 0, 0, 0, 4'd0, 4'd7, 4'b0100, 0, 0, "tog_hold_b");
      step(0, 1, 0, 1, 1, 4'd0, 4'd8, 4'b1100, 0, 1, "tog_up");
      step(0, 1, 0, 1, 0, 4'd0, 4'd7, 4'b0100, 0, 1, "tog_dn");
      step(0, 1, 0, 1, 1, 4'd0, 4'd8, 4'b1100, 0, 1, "tog_up2");

      // Saturation at both ends
      step(1, 0, 0, 0, 1, 4'd0,  4'd0,  4'b0000, 0, 0, "sat_reset");
      step(1, 1, 1, 0, 1, 4'd14, 4'd14, 4'b1001, 0, 0, "sat_load14");
      step(1, 1, 0, 1, 1, 4'd0,  4'd15, 4'b1000, 0, 1, "sat_14to15");
      step(1, 1, 0, 1, 1, 4'd0,  4'd15, 4'b1000, 1, 0, "sat_block1");
      step(1, 1, 0, 1, 1, 4'd0,  4'd15, 4'b1000, 1, 0, "sat_block2");
      step(1, 1, 0, 1, 1, 4'd0,  4'd15, 4'b1000, 1, 0, "sat_block3");
      step(1, 1, 0, 0, 1, 4'd0,  4'd15, 4'b1000, 0, 0, "sat_hold");
      step(1, 1, 1, 0, 0, 4'd0,  4'd0,  4'b0000, 0, 0, "sat_load0");
      step(1, 1, 0, 1, 0, 4'd0,  4'd0,  4'b0000, 1, 0, "sat_block_lo");
      step(1, 1, 0, 1, 1, 4'd0,  4'd1,  4'b0001, 0, 1, "sat_up_lo");

      // Synchronous reset mid-count with RESET_VAL=5
      step(2, 0, 0, 0, 1, 4'd0,  4'd5,  4'b0111, 0, 0, "rv5_reset");
      step(2, 1, 1, 0, 1, 4'd10, 4'd10, 4'b1111, 0, 0, "rv5_load10");
      step(2, 1, 0, 1, 1, 4'd0,  4'd11, 4'b1110, 0, 1, "rv5_to11");
      step(2, 0, 1, 1, 1, 4'd3,  4'd5,  4'b0111, 0, 0, "rv5_midreset");
      // rst_n released mid-cycle; outputs must still read the reset value
      rst_n[2] = 1'b1; load[2] = 1'b0; en[2] = 1'b0;
      #1;
      sb.push_back('{id: 2, b: 4'd5, g: 4'b0111, tc: 1'b0, hd: 1'b0, nm: "rv5_release"});
      step(2, 1, 0, 0, 1, 4'd0,  4'd5,  4'b0111, 0, 0, "rv5_hold");
      step(2, 1, 0, 1, 1, 4'd0,  4'd6,  4'b0101, 0, 1, "rv5_first_step");

      // Bounded drain of the scoreboard
      for (int t = 0; t < 4 && sb.size() > 0; t++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending entries, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
